bus_fabric: RTL and testbench

- Parametrised address decoder, chip-select generator and read-data mux for the 65C02 system bus.
- Replaces hand-coded fixed RAM/ROM/ACIA decoding with NUM_SLV configurable regions.
- Adds per-region wait states via RDY stretching, a registered address-pad output, and an unmapped-access counter.
- Sits between cpu_65c02 and the synchronous slaves (RAM, ROM, ACIA, external bus).

---
 rtl/bus_fabric_if.sv | 30 +++
 rtl/bus_fabric.sv | 145 ++++++++++++++
 tb/tb_bus_fabric.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/bus_fabric_if.sv
// CPU-side bus bundle between the 65C02 and the decode fabric.
// master: CPU / slave-data side (drives address, write data, slave read data).
// slave : the fabric (drives chip selects, RDY, read mux and status).
interface bus_fabric_if #(
  parameter int NUM_SLV = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 8
);
  logic [ADDR_W-1:0]              cpu_ab;
  logic                           cpu_we;
  logic [DATA_W-1:0]              cpu_do;
  logic [DATA_W-1:0]              cpu_di;
  logic                           cpu_rdy;
  logic [NUM_SLV-1:0]             slv_en;
  logic                           slv_we;
  logic [DATA_W-1:0]              slv_wdata;
  logic [NUM_SLV-1:0][DATA_W-1:0] slv_rdata;
  logic [ADDR_W-1:0]              addr_pad;
  logic [7:0]                     unmapped_cnt;

  modport master (
    output cpu_ab, cpu_we, cpu_do, slv_rdata,
    input  cpu_di, cpu_rdy, slv_en, slv_we, slv_wdata, addr_pad, unmapped_cnt
  );

  modport slave (
    input  cpu_ab, cpu_we, cpu_do, slv_rdata,
    output cpu_di, cpu_rdy, slv_en, slv_we, slv_wdata, addr_pad, unmapped_cnt
  );
endinterface

// File: rtl/bus_fabric.sv
// 65C02 bus fabric: NUM_SLV-region address decoder with lowest-index priority,
// per-region RDY wait states, registered read-select mux, registered address
// pad and a saturating unmapped-access counter.

// One decoded region: inclusive [BASE, LIMIT] range test.
module bus_fabric_rgn #(
  parameter int                ADDR_W = 16,
  parameter logic [ADDR_W-1:0] BASE   = '0,
  parameter logic [ADDR_W-1:0] LIMIT  = '1
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_hit
);
  logic [ADDR_W:0] w_lo_diff;
  logic [ADDR_W:0] w_hi_diff;

  // Range test via borrow bits so a zero base or all-ones limit does not
  // degenerate into a constant comparison.
  always_comb begin
    w_lo_diff = {1'b0, i_addr} - {1'b0, BASE};
    w_hi_diff = {1'b0, LIMIT}  - {1'b0, i_addr};
    o_hit     = ~w_lo_diff[ADDR_W] & ~w_hi_diff[ADDR_W];
  end
endmodule

module bus_fabric #(
  parameter int                        NUM_SLV      = 4,
  parameter int                        ADDR_W       = 16,
  parameter int                        DATA_W       = 8,
  parameter logic [NUM_SLV*ADDR_W-1:0] REG_BASE     = {16'h8000, 16'hC000, 16'h8000, 16'h0000},
  parameter logic [NUM_SLV*ADDR_W-1:0] REG_LIMIT    = {16'hBFFF, 16'hFFFF, 16'h800F, 16'h7FFF},
  parameter logic [NUM_SLV*4-1:0]      REG_WAIT     = {4'd2, 4'd0, 4'd1, 4'd0},
  parameter logic [DATA_W-1:0]         DEFAULT_DATA = 8'hEA
) (
  input  logic         clk,
  input  logic         resb,
  bus_fabric_if.slave  bus
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  logic [NUM_SLV-1:0] w_hit_raw;
  logic [NUM_SLV-1:0] w_hit;
  logic [3:0]         w_wait;
  logic               w_miss;
  logic               w_rdy;
  state_t             r_state, w_nstate;
  logic [3:0]         r_cnt, w_ncnt;
  logic [NUM_SLV-1:0] r_sel;
  logic               r_rd_miss;
  logic [ADDR_W-1:0]  r_addr_pad;
  logic [7:0]         r_unm_cnt;
  logic [DATA_W-1:0]  w_rmux;

  for (genvar g = 0; g < NUM_SLV; g++) begin : g_rgn
    bus_fabric_rgn #(
      .ADDR_W (ADDR_W),
      .BASE   (REG_BASE[g*ADDR_W +: ADDR_W]),
      .LIMIT  (REG_LIMIT[g*ADDR_W +: ADDR_W])
    ) u_rgn (
      .i_addr (bus.cpu_ab),
      .o_hit  (w_hit_raw[g])
    );
  end

  // Priority encode raw hits: the lowest matching index owns the access.
  always_comb begin
    w_hit  = '0;
    w_wait = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (w_hit_raw[i] && (w_hit == '0)) begin
        w_hit[i] = 1'b1;
        w_wait   = REG_WAIT[i*4 +: 4];
      end
    end
    w_miss = (w_hit == '0);
  end

  // Wait-state FSM register; reset drops any stall in progress.
  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
    end
  end

  // Wait-state next-state / RDY: a region with W waits stretches RDY W cycles.
  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_rdy    = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (w_wait != 4'd0) begin
          w_rdy    = 1'b0;
          w_ncnt   = w_wait - 4'd1;
          w_nstate = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt != 4'd0) begin
          w_rdy  = 1'b0;
          w_ncnt = r_cnt - 4'd1;
        end else begin
          w_nstate = S_IDLE;
        end
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  // Completed-access capture: read slot select, pad address, unmapped count.
  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      r_sel      <= '0;
      r_rd_miss  <= 1'b0;
      r_addr_pad <= '0;
      r_unm_cnt  <= '0;
    end else if (w_rdy) begin
      r_sel      <= w_hit & {NUM_SLV{~bus.cpu_we}};
      r_rd_miss  <= ~bus.cpu_we & w_miss;
      r_addr_pad <= bus.cpu_ab;
      if (w_miss && (r_unm_cnt != 8'hFF))
        r_unm_cnt <= r_unm_cnt + 8'd1;
    end
  end

  // Read mux over the one-hot registered select (slaves have 1-cycle latency).
  always_comb begin
    w_rmux = '0;
    for (int i = 0; i < NUM_SLV; i++)
      if (r_sel[i]) w_rmux = bus.slv_rdata[i];
  end

  // Strobe only on the completing cycle so side-effect registers see one write.
  assign bus.slv_we       = bus.cpu_we & w_rdy & ~w_miss;
  assign bus.slv_en       = w_hit;
  assign bus.slv_wdata    = bus.cpu_do;
  assign bus.cpu_rdy      = w_rdy;
  assign bus.cpu_di       = (r_rd_miss || (r_sel == '0)) ? DEFAULT_DATA : w_rmux;
  assign bus.addr_pad     = r_addr_pad;
  assign bus.unmapped_cnt = r_unm_cnt;
endmodule

// File: tb/tb_bus_fabric.sv
// Scoreboarded bench for bus_fabric: directed accesses push expected results,
// a negedge monitor pops and checks on each completed access (cpu_rdy=1).
// A second instance with every region empty exercises the unmapped path.
module tb_bus_fabric;
  logic clk = 1'b0;
  logic resb;
  always #5 clk = ~clk;

  bus_fabric_if #(.NUM_SLV(4), .ADDR_W(16), .DATA_W(8)) bi ();
  bus_fabric_if #(.NUM_SLV(4), .ADDR_W(16), .DATA_W(8)) bu ();

  bus_fabric u_dut (.clk(clk), .resb(resb), .bus(bi));

  bus_fabric #(
    .REG_BASE  ({4{16'hFFFF}}),
    .REG_LIMIT ({4{16'h0000}}),
    .REG_WAIT  ({4{4'd0}})
  ) u_unm (.clk(clk), .resb(resb), .bus(bu));

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wd;
    logic [3:0]  en;
    int          stall;
    logic [7:0]  rd;
  } vec_t;

  vec_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic act   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, a, e);
    end
  endtask

  // Monitor: counts stall cycles, checks strobe/enables, then the cycle after
  // completion checks read data and the pad.
  vec_t cur, pend_v;
  logic pend  = 1'b0;
  int   stall = 0;
  always @(negedge clk) begin
    if (pend) begin
      chk($sformatf("cpu_di@%h", pend_v.addr), {24'd0, bi.cpu_di}, {24'd0, pend_v.rd});
      chk($sformatf("addr_pad@%h", pend_v.addr), {16'd0, bi.addr_pad}, {16'd0, pend_v.addr});
      pend = 1'b0;
    end
    if (act) begin
      if (!bi.cpu_rdy) begin
        stall++;
        chk("slv_we_in_stall", {31'd0, bi.slv_we}, 32'd0);
        if (sb.size() > 0)
          chk($sformatf("en_stall@%h", sb[0].addr), {28'd0, bi.slv_en}, {28'd0, sb[0].en});
      end else if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        cur = sb.pop_front();
        chk($sformatf("slv_en@%h", cur.addr), {28'd0, bi.slv_en}, {28'd0, cur.en});
        chk($sformatf("slv_we@%h", cur.addr), {31'd0, bi.slv_we}, {31'd0, cur.we});
        chk($sformatf("stall@%h", cur.addr), stall, cur.stall);
        if (cur.we)
          chk($sformatf("wdata@%h", cur.addr), {24'd0, bi.slv_wdata}, {24'd0, cur.wd});
        pend_v = cur;
        pend   = 1'b1;
        stall  = 0;
      end
    end
  end

  task automatic do_acc(input vec_t v);
    int n;
    sb.push_back(v);
    bi.cpu_ab = v.addr;
    bi.cpu_we = v.we;
    bi.cpu_do = v.wd;
    act = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bi.cpu_rdy && n < 20);
    if (n >= 20) chk($sformatf("timeout@%h", v.addr), 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    resb = 1'b0;
    bi.cpu_ab = 16'h0000; bi.cpu_we = 1'b0; bi.cpu_do = 8'h00;
    bi.slv_rdata = {8'h3C, 8'hA5, 8'hC3, 8'h5A};
    bu.cpu_ab = 16'hC000; bu.cpu_we = 1'b0; bu.cpu_do = 8'h00;
    bu.slv_rdata = {4{8'h11}};
    #12;
    // Reset state
    chk("rst_cpu_di", {24'd0, bi.cpu_di}, 32'hEA);
    chk("rst_addr_pad", {16'd0, bi.addr_pad}, 32'd0);
    chk("rst_unm", {24'd0, bi.unmapped_cnt}, 32'd0);
    chk("rst_rdy", {31'd0, bi.cpu_rdy}, 32'd1);
    chk("rst_en", {28'd0, bi.slv_en}, 32'd1);
    @(negedge clk); resb = 1'b1;

    // Unmapped instance: every cycle is a completed unmapped access
    @(posedge clk); #1;
    chk("unm_di", {24'd0, bu.cpu_di}, 32'hEA);
    chk("unm_cnt1", {24'd0, bu.unmapped_cnt}, 32'd1);
    chk("unm_en", {28'd0, bu.slv_en}, 32'd0);
    for (int i = 2; i <= 300; i++) begin
      bu.cpu_we = i[0];
      bu.cpu_ab = 16'(i * 97);
      @(negedge clk);
      if (i == 3) chk("unm_we", {31'd0, bu.slv_we}, 32'd0);
      @(posedge clk); #1;
      if (i == 254) chk("unm_cnt254", {24'd0, bu.unmapped_cnt}, 32'd254);
      if (i == 255) chk("unm_cnt255", {24'd0, bu.unmapped_cnt}, 32'hFF);
      if (i == 300) chk("unm_cnt300", {24'd0, bu.unmapped_cnt}, 32'hFF);
    end
    chk("unm_di_after_wr", {24'd0, bu.cpu_di}, 32'hEA);

    // Mapped instance, directed vectors
    do_acc('{16'h0010, 1'b0, 8'h00, 4'b0001, 0, 8'h5A});
    do_acc('{16'h8003, 1'b1, 8'h33, 4'b0010, 1, 8'hEA});
    do_acc('{16'h9000, 1'b0, 8'h00, 4'b1000, 2, 8'h3C});
    do_acc('{16'h9001, 1'b0, 8'h00, 4'b1000, 2, 8'h3C});
    do_acc('{16'h8005, 1'b0, 8'h00, 4'b0010, 1, 8'hC3});
    do_acc('{16'hC000, 1'b0, 8'h00, 4'b0100, 0, 8'hA5});
    do_acc('{16'hFFFF, 1'b0, 8'h00, 4'b0100, 0, 8'hA5});
    do_acc('{16'h8010, 1'b0, 8'h00, 4'b1000, 2, 8'h3C});
    do_acc('{16'h800F, 1'b0, 8'h00, 4'b0010, 1, 8'hC3});
    do_acc('{16'hBFFF, 1'b1, 8'h5C, 4'b1000, 2, 8'hEA});
    do_acc('{16'h0000, 1'b0, 8'h00, 4'b0001, 0, 8'h5A});
    do_acc('{16'h7FFF, 1'b0, 8'h00, 4'b0001, 0, 8'h5A});
    act = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    chk("mapped_unm_cnt", {24'd0, bi.unmapped_cnt}, 32'd0);

    // Reset in the middle of a region-3 write stall
    @(posedge clk); #1;
    bi.cpu_ab = 16'h9000; bi.cpu_we = 1'b1; bi.cpu_do = 8'h77;
    @(negedge clk);
    chk("wr3_rdy0", {31'd0, bi.cpu_rdy}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wr3_we_stall", {31'd0, bi.slv_we}, 32'd0);
    #2 resb = 1'b0;
    #1;
    chk("rstw_we", {31'd0, bi.slv_we}, 32'd0);
    chk("rstw_di", {24'd0, bi.cpu_di}, 32'hEA);
    chk("rstw_pad", {16'd0, bi.addr_pad}, 32'd0);
    chk("rstw_unm", {24'd0, bu.unmapped_cnt}, 32'd0);
    bi.cpu_ab = 16'h0010; bi.cpu_we = 1'b0;
    #1;
    chk("rstw_idle_rdy", {31'd0, bi.cpu_rdy}, 32'd1);
    @(negedge clk); resb = 1'b1;
    @(negedge clk);
    chk("post_rst_we", {31'd0, bi.slv_we}, 32'd0);
    chk("post_rst_rdy", {31'd0, bi.cpu_rdy}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
